// File: rtl/cpu_pkg.sv
// Shared opcode, state encodings and decode helper for the accumulator CPU controller.
package cpu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_HLT = 3'b000;
  localparam logic [OPW-1:0] OP_SKZ = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_LDA = 3'b101;
  localparam logic [OPW-1:0] OP_STA = 3'b110;
  localparam logic [OPW-1:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_S0        = 4'd1,
    ST_S1        = 4'd2,
    ST_S2        = 4'd3,
    ST_S3        = 4'd4,
    ST_S4        = 4'd5,
    ST_S5        = 4'd6,
    ST_S6        = 4'd7,
    ST_S7        = 4'd8,
    ST_HALTED    = 4'd9,
    ST_STEP_WAIT = 4'd10
  } state_t;

  // Ops whose operand comes from memory and end with an accumulator load.
  function automatic logic is_mem_read(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Read-phase wait timer: reloaded on entry to a read phase, flags the final cycle of the phase.
module cpu_wait_timer #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic phase_last_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (start_i)       cnt_q <= 4'(WAIT_CYCLES);
    else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign phase_last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Instruction-cycle sequencer for the 8-bit accumulator CPU.
// Optional single-step support is enabled with CPU_CTRL_SINGLE_STEP_EN.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int WAIT_CYCLES = 0
) (
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [OP_W-1:0] op_code,
  input  logic            zero,
  output logic            rd,
  output logic            wr,
  output logic            load_ir,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_acc,
  output logic            alu_enable,
  output logic            datactl_ena,
  output logic            halt,
  output logic            instr_done,
  output logic [3:0]      state
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            skz_q;
  logic            phase_last;
  logic            tmr_start;
  logic            mem_op;

  assign mem_op = is_mem_read(op_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:     state_d = phase_last ? ST_S1 : ST_S0;
      ST_S1:     state_d = phase_last ? ST_S2 : ST_S1;
      ST_S2:     state_d = ST_S3;
      ST_S3: begin
        if (op_q == OP_HLT)             state_d = ST_HALTED;
        else if (mem_op && !phase_last) state_d = ST_S3;
        else                            state_d = ST_S4;
      end
      ST_S4:     state_d = ST_S5;
      ST_S5:     state_d = ST_S6;
      ST_S6:     state_d = ST_S7;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      ST_S7:        state_d = step_mode ? ST_STEP_WAIT : (ena ? ST_S0 : ST_IDLE);
      ST_STEP_WAIT: state_d = step ? ST_S0 : (!ena ? ST_IDLE : ST_STEP_WAIT);
`else
      ST_S7:     state_d = ena ? ST_S0 : ST_IDLE;
`endif
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Non-reading ops also reload on S3 entry; they simply ignore phase_last.
  assign tmr_start = ((state_d == ST_S0) || (state_d == ST_S1) || (state_d == ST_S3))
                     && (state_d != state_q);

  cpu_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk          (clk),
    .rst          (rst),
    .start_i      (tmr_start),
    .phase_last_o (phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HLT;
      skz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Anything outside the defined opcodes decodes as HLT.
      if (state_q == ST_S2) begin
        case (op_code)
          OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STA, OP_JMP: op_q <= op_code;
          default:                                                op_q <= OP_HLT;
        endcase
      end
      skz_q <= (state_q == ST_S5) && (op_q == OP_SKZ) && zero;
    end
  end

  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    alu_enable  = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      ST_S0: begin
        rd      = 1'b1;
        load_ir = phase_last;
      end
      ST_S1: begin
        rd      = 1'b1;
        load_ir = phase_last;
        inc_pc  = phase_last;
      end
      ST_S3: begin
        halt = (op_q == OP_HLT);
        rd   = mem_op;
      end
      ST_S4: begin
        alu_enable  = (op_q != OP_HLT);
        rd          = mem_op;
        datactl_ena = (op_q == OP_STA);
      end
      ST_S5: begin
        load_acc    = mem_op;
        datactl_ena = (op_q == OP_STA);
        wr          = (op_q == OP_STA);
        load_pc     = (op_q == OP_JMP);
        inc_pc      = (op_q == OP_SKZ) && zero;
      end
      ST_S6: begin
        datactl_ena = (op_q == OP_STA);
        inc_pc      = (op_q == OP_SKZ) && skz_q;
      end
      ST_S7:     instr_done = 1'b1;
      ST_HALTED: halt       = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized bench for cpu_seq_ctrl: two instances (WAIT_CYCLES 0 and 2) against a phase-table model.
module tb_cpu_seq_ctrl;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDo = 3'd3,
                         XORo = 3'd4, LDA = 3'd5, STA = 3'd6, JMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_r  [2];
  logic       ena_r  [2];
  logic [2:0] op_r   [2];
  logic       zero_r [2];
  logic       rd_w [2], wr_w [2], lir_w [2], ipc_w [2], lpc_w [2], lacc_w [2];
  logic       alu_w [2], dctl_w [2], halt_w [2], done_w [2];
  logic [3:0] st_w [2];

  int n_chk  = 0;
  int n_fail = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_seq_ctrl #(.OP_W(3), .WAIT_CYCLES(2*g)) u_dut (
      .clk(clk), .rst(rst_r[g]), .ena(ena_r[g]), .op_code(op_r[g]), .zero(zero_r[g]),
      .rd(rd_w[g]), .wr(wr_w[g]), .load_ir(lir_w[g]), .inc_pc(ipc_w[g]),
      .load_pc(lpc_w[g]), .load_acc(lacc_w[g]), .alu_enable(alu_w[g]),
      .datactl_ena(dctl_w[g]), .halt(halt_w[g]), .instr_done(done_w[g]), .state(st_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word layout: {rd,wr,load_ir,inc_pc,load_pc,load_acc,alu_en,datactl,halt,done,state}
  function automatic logic [13:0] ev(bit r, bit w, bit lir, bit ipc, bit lpc, bit lacc,
                                     bit alu, bit dctl, bit hlt, bit done, int st);
    return {r, w, lir, ipc, lpc, lacc, alu, dctl, hlt, done, 4'(st)};
  endfunction

  function automatic logic [13:0] obs(int k);
    return {rd_w[k], wr_w[k], lir_w[k], ipc_w[k], lpc_w[k], lacc_w[k],
            alu_w[k], dctl_w[k], halt_w[k], done_w[k], st_w[k]};
  endfunction

  // Expected per-cycle trace of one instruction, phase by phase.
  function automatic void build_exp(logic [2:0] op, bit z, int w);
    bit mem = (op == ADD) || (op == ANDo) || (op == XORo) || (op == LDA);
    bit sta = (op == STA);
    bit skz = (op == SKZ) && z;
    exp_q.delete();
    for (int i = 0; i <= w; i++) exp_q.push_back(ev(1,0,i==w,0,0,0,0,0,0,0,1));
    for (int i = 0; i <= w; i++) exp_q.push_back(ev(1,0,i==w,i==w,0,0,0,0,0,0,2));
    exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0,3));
    if (op == HLT) begin
      exp_q.push_back(ev(0,0,0,0,0,0,0,0,1,0,4));
      return;
    end
    for (int i = 0; i < (mem ? w + 1 : 1); i++) exp_q.push_back(ev(mem,0,0,0,0,0,0,0,0,0,4));
    exp_q.push_back(ev(mem,0,0,0,0,0,1,sta,0,0,5));
    exp_q.push_back(ev(0,sta,0,skz,op==JMP,mem,0,sta,0,0,6));
    exp_q.push_back(ev(0,0,0,skz,0,0,0,sta,0,0,7));
    exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1,8));
  endfunction

  task automatic idle_kick(input int k);
    @(negedge clk);
    chk($sformatf("k%0d idle", k), 32'(obs(k)), 32'(ev(0,0,0,0,0,0,0,0,0,0,0)));
    ena_r[k] = 1'b1;
  endtask

  task automatic do_reset(input int k);
    rst_r[k] = 1'b1;
    ena_r[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("k%0d reset", k), 32'(obs(k)), 32'd0);
    rst_r[k] = 1'b0;
  endtask

  // ena stays 1 until S4, then takes ena_end, so it is what S7 sees.
  task automatic run_instr(input int k, input logic [2:0] op, input bit z,
                           input bit ena_end, input int stop_st);
    logic [13:0] o;
    op_r[k]   = op;
    zero_r[k] = z;
    build_exp(op, z, 2*k);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = obs(k);
      chk($sformatf("k%0d op%0d z%0d cyc%0d", k, op, z, i), 32'(o), 32'(exp_q[i]));
      chk($sformatf("k%0d rd_wr cyc%0d", k, i), 32'(o[13] & o[12]), 32'd0);
      chk($sformatf("k%0d pc_excl cyc%0d", k, i), 32'(o[10] & o[9]), 32'd0);
      if (exp_q[i][3:0] == 4'd5) ena_r[k] = ena_end;
      if (stop_st != 0 && int'(exp_q[i][3:0]) == stop_st) return;
    end
    if (op != HLT && !ena_end) begin
      @(negedge clk);
      chk($sformatf("k%0d stop_idle", k), 32'(obs(k)), 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_r[k] = 1'b1; ena_r[k] = 1'b0; op_r[k] = 3'd0; zero_r[k] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      do_reset(k);
      idle_kick(k);
      run_instr(k, ADD, 1'b0, 1'b1, 0);
      run_instr(k, STA, 1'b0, 1'b1, 0);
      run_instr(k, SKZ, 1'b1, 1'b1, 0);
      run_instr(k, SKZ, 1'b0, 1'b1, 0);
      run_instr(k, LDA, 1'b0, 1'b1, 0);
      run_instr(k, JMP, 1'b1, 1'b0, 0);
      idle_kick(k);
      for (int n = 0; n < 25; n++) begin
        logic [2:0] op;
        bit z, e;
        op = 3'($urandom_range(1, 7));
        z  = 1'($urandom_range(0, 1));
        e  = ($urandom_range(0, 3) != 0);
        run_instr(k, op, z, e, 0);
        if (!e) idle_kick(k);
      end
      // Reset while STA is in writeback: no leftover wr/bus drive.
      run_instr(k, STA, 1'b0, 1'b1, 6);
      rst_r[k] = 1'b1;
      @(negedge clk);
      chk($sformatf("k%0d sta_abort", k), 32'(obs(k)), 32'd0);
      rst_r[k] = 1'b0;
      ena_r[k] = 1'b0;
      @(negedge clk);
      chk($sformatf("k%0d post_abort", k), 32'(obs(k)), 32'd0);
      idle_kick(k);
      run_instr(k, HLT, 1'b0, 1'b1, 0);
      for (int c = 0; c < 20; c++) begin
        ena_r[k] = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("k%0d halted%0d", k, c), 32'(obs(k)),
            32'(ev(0,0,0,0,0,0,0,0,1,0,9)));
      end
      rst_r[k] = 1'b1;
      @(negedge clk);
      chk($sformatf("k%0d hlt_rst", k), 32'(obs(k)), 32'd0);
      rst_r[k] = 1'b0;
      ena_r[k] = 1'b0;
      @(negedge clk);
      chk($sformatf("k%0d hlt_idle", k), 32'(obs(k)), 32'd0);
      rst_r[k] = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
